// File: rtl/uart_frame_tx_fifo.sv
// ============================================================================
// uart_frame_tx_fifo
// ----------------------------------------------------------------------------
// UART frame transmitter fed by a small circular-buffer FIFO. Each queued word
// goes out as one frame:
//     start(0), DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stops(1).
// Every bit lasts P = prescale clock cycles (0 is treated as 1). When the next
// word is already queued, frames are sent back-to-back with no idle cycle.
//
// Ports
//   CLK         in   1             UART-domain clock
//   RST         in   1             asynchronous active-low reset
//   wr_data     in   DATA_WIDTH    word to enqueue
//   wr_valid    in   1             enqueue request
//   wr_ready    out  1             FIFO not full (decoded from fifo_count)
//   tx_en       in   1             1: frames may start, 0: hold after current frame
//   par_en      in   1             1: append a parity bit
//   par_typ     in   1             0: even parity, 1: odd parity
//   stop2       in   1             1: two stop bits
//   prescale    in   PRESC_W       clock cycles per bit
//   tx_out      out  1             registered serial line, idles high
//   busy        out  1             transmitter not idle
//   frame_done  out  1             high during the last cycle of each frame
//   fifo_count  out  PTR_W+1       words currently queued
// ============================================================================
module uart_frame_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  tx_en,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    input  logic [PRESC_W-1:0]    prescale,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic [PTR_W:0]        fifo_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Data-bit index 0..DATA_WIDTH-1 (DATA_WIDTH is 5..9).
    localparam int BIT_W = (DATA_WIDTH > 8) ? 4 : 3;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_head;

    // ------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [PRESC_W-1:0]    r_presc_cnt;
    logic [PRESC_W-1:0]    r_presc_lat;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_bit;
    logic                  r_par_en;
    logic                  r_stop2;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_frame_done;

    logic [2:0]            w_state_next;
    logic [PRESC_W-1:0]    w_presc_next;
    logic [PRESC_W-1:0]    w_presc_lat_next;
    logic [BIT_W-1:0]      w_bit_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_par_bit_next;
    logic                  w_par_en_next;
    logic                  w_stop2_next;
    logic                  w_tx_next;
    logic                  w_frame_done_next;

    logic [PRESC_W-1:0]    w_p_eff;
    logic [PRESC_W-1:0]    w_presc_reload;
    logic                  w_bit_end;
    logic                  w_last;
    logic                  w_start;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign w_full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign wr_ready   = ~w_full;
    // Gated on the registered count only: a write into a full FIFO is lost
    // even when the transmitter pops in the same cycle.
    assign w_push     = wr_valid & ~w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign fifo_count = r_count;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter next-state logic
    // ------------------------------------------------------------------
    assign w_p_eff        = (prescale == '0) ? PRESC_W'(1) : prescale;
    assign w_presc_reload = r_presc_lat - PRESC_W'(1);
    assign w_bit_end      = (r_presc_cnt == '0);

    // Last cycle of the final stop bit.
    assign w_last  = (r_state == S_STOP) && w_bit_end &&
                     (!r_stop2 || (r_bit_cnt == BIT_W'(1)));

    // A new frame is launched from idle or straight out of the previous one.
    assign w_start = ((r_state == S_IDLE) || w_last) && tx_en && (r_count != '0);
    assign w_pop   = w_start;

    always_comb begin
        w_state_next     = r_state;
        w_presc_next     = r_presc_cnt;
        w_presc_lat_next = r_presc_lat;
        w_bit_next       = r_bit_cnt;
        w_shift_next     = r_shift;
        w_par_bit_next   = r_par_bit;
        w_par_en_next    = r_par_en;
        w_stop2_next     = r_stop2;
        w_tx_next        = r_tx;

        if (r_state != S_IDLE) begin
            if (!w_bit_end) begin
                w_presc_next = r_presc_cnt - PRESC_W'(1);
            end else begin
                w_presc_next = w_presc_reload;
            end
        end

        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_tx_next    = r_shift[0];
                    w_shift_next = r_shift >> 1;
                    w_bit_next   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BIT_W'(DATA_WIDTH-1)) begin
                        if (r_par_en) begin
                            w_state_next = S_PARITY;
                            w_tx_next    = r_par_bit;
                        end else begin
                            w_state_next = S_STOP;
                            w_tx_next    = 1'b1;
                            w_bit_next   = '0;
                        end
                    end else begin
                        w_tx_next    = r_shift[0];
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
                    w_bit_next   = '0;
                end
            end
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    if (r_stop2 && (r_bit_cnt == '0)) begin
                        w_bit_next = BIT_W'(1);
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase

        // Launch overrides whatever the state case decided; configuration
        // is captured here and held for the whole frame.
        if (w_start) begin
            w_state_next     = S_START;
            w_tx_next        = 1'b0;
            w_shift_next     = w_head;
            w_par_bit_next   = (^w_head) ^ par_typ;
            w_par_en_next    = par_en;
            w_stop2_next     = stop2;
            w_presc_lat_next = w_p_eff;
            w_presc_next     = w_p_eff - PRESC_W'(1);
            w_bit_next       = '0;
        end

        // frame_done is registered, so it is asserted when the next cycle
        // is going to be the last cycle of the final stop bit.
        w_frame_done_next = (w_state_next == S_STOP) && (w_presc_next == '0) &&
                            (!w_stop2_next || (w_bit_next == BIT_W'(1)));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= S_IDLE;
            r_presc_cnt  <= '0;
            r_presc_lat  <= PRESC_W'(1);
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_par_en     <= 1'b0;
            r_stop2      <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_presc_cnt  <= w_presc_next;
            r_presc_lat  <= w_presc_lat_next;
            r_bit_cnt    <= w_bit_next;
            r_shift      <= w_shift_next;
            r_par_bit    <= w_par_bit_next;
            r_par_en     <= w_par_en_next;
            r_stop2      <= w_stop2_next;
            r_tx         <= w_tx_next;
            r_busy       <= (w_state_next != S_IDLE);
            r_frame_done <= w_frame_done_next;
        end
    end

    assign tx_out     = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_frame_tx_fifo.sv
// ============================================================================
// tb_uart_frame_tx_fifo
// ----------------------------------------------------------------------------
// Directed scenarios followed by randomized traffic. A frame-level reference
// model (queue of words plus a queue of expected line samples built from the
// framing rules) predicts tx_out, busy, frame_done, fifo_count and wr_ready on
// every cycle.
// ============================================================================
module tb_uart_frame_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int PRW   = 6;

    logic           CLK;
    logic           RST;
    logic [DW-1:0]  wr_data;
    logic           wr_valid;
    logic           wr_ready;
    logic           tx_en;
    logic           par_en;
    logic           par_typ;
    logic           stop2;
    logic [PRW-1:0] prescale;
    logic           tx_out;
    logic           busy;
    logic           frame_done;
    logic [PW:0]    fifo_count;

    uart_frame_tx_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .PTR_W      (PW),
        .PRESC_W    (PRW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx_en      (tx_en),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    int fifo_q[$];
    bit line_q[$];

    // Directed-scenario recorders
    int   n_fd;
    int   n_busy;
    bit   rec_en;
    int   rec_idx;
    logic rec [128];
    int   n_frames = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Expected line samples for one frame, built from the framing rules.
    function automatic void add_frame(int w, bit pe, bit pt, bit s2, int p);
        int pp;
        int ones;
        bit bits[$];
        pp   = (p == 0) ? 1 : p;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            bits.push_back(((w >> i) & 1) != 0);
            ones += (w >> i) & 1;
        end
        if (pe) bits.push_back(((ones % 2) != 0) ^ pt);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int j = 0; j < pp; j++) line_q.push_back(bits[k]);
        end
    endfunction

    // One clock cycle: check outputs for the current cycle, then advance the model.
    task automatic cycle();
        bit          acc;
        bit          st;
        int          w;
        logic [DW-1:0] d;
        bit          pe, pt, s2;
        int          p;
        chk("tx_out",     tx_out,     (line_q.size() == 0) ? 1'b1 : line_q[0]);
        chk("busy",       busy,       line_q.size() != 0);
        chk("frame_done", frame_done, line_q.size() == 1);
        chk("fifo_count", fifo_count, fifo_q.size());
        chk("wr_ready",   wr_ready,   fifo_q.size() < DEPTH);
        if (frame_done === 1'b1) n_fd++;
        if (busy === 1'b1) begin
            n_busy++;
            if (rec_en && rec_idx < 128) begin
                rec[rec_idx] = tx_out;
                rec_idx++;
            end
        end
        acc = wr_valid && (fifo_q.size() < DEPTH);
        st  = (line_q.size() <= 1) && tx_en && (fifo_q.size() != 0);
        d   = wr_data;
        pe  = par_en;
        pt  = par_typ;
        s2  = stop2;
        p   = int'(prescale);
        @(posedge CLK);
        if (line_q.size() != 0) void'(line_q.pop_front());
        if (st) begin
            w = fifo_q.pop_front();
            add_frame(w, pe, pt, s2, p);
            n_frames++;
            $display("frame %0d start word=%02h P=%0d par_en=%0b par_typ=%0b stop2=%0b",
                     n_frames, w, p, pe, pt, s2);
        end
        if (acc) fifo_q.push_back(int'(d));
        @(negedge CLK);
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while ((line_q.size() != 0 || fifo_q.size() != 0) && k < max_cycles) begin
            cycle();
            k++;
        end
        chk("drain_in_budget", k < max_cycles, 1'b1);
    endtask

    task automatic run_frame(input logic [DW-1:0] w, input int n);
        n_fd     = 0;
        n_busy   = 0;
        rec_idx  = 0;
        rec_en   = 1'b1;
        wr_data  = w;
        wr_valid = 1'b1;
        cycle();
        wr_valid = 1'b0;
        repeat (n) cycle();
        rec_en = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        wr_valid = 1'b0;
        RST      = 1'b0;
        #1;
        chk({tag, "_tx_out"},     tx_out,     1'b1);
        chk({tag, "_busy"},       busy,       1'b0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_wr_ready"},   wr_ready,   1'b1);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        line_q.delete();
        fifo_q.delete();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_pat;
        bit         did_rst;
        a5_pat   = 10'b1101001010;
        RST      = 1'b0;
        wr_data  = '0;
        wr_valid = 1'b0;
        tx_en    = 1'b0;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        stop2    = 1'b0;
        prescale = 6'd4;
        rec_en   = 1'b0;
        rec_idx  = 0;
        n_fd     = 0;
        n_busy   = 0;
        repeat (2) @(negedge CLK);
        chk("rst_tx_out",     tx_out,     1'b1);
        chk("rst_busy",       busy,       1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_wr_ready",   wr_ready,   1'b1);
        RST = 1'b1;
        @(negedge CLK);

        // 0xA5, P=4, 8N1: 40-cycle frame, one frame_done pulse.
        tx_en = 1'b1;
        run_frame(8'hA5, 50);
        chk("a5_frame_done_pulses", n_fd, 1);
        chk("a5_frame_cycles", n_busy, 40);
        for (int i = 0; i < 10; i++) chk("a5_bit", rec[i*4+2], a5_pat[i]);

        // 0x03 with even parity, then odd parity and two stop bits.
        par_en  = 1'b1;
        par_typ = 1'b0;
        run_frame(8'h03, 50);
        chk("even_parity_bit", rec[38], 1'b0);
        chk("even_frame_cycles", n_busy, 44);
        par_typ = 1'b1;
        stop2   = 1'b1;
        run_frame(8'h03, 55);
        chk("odd_parity_bit", rec[38], 1'b1);
        chk("stop2_frame_cycles", n_busy, 48);
        chk("stop2_bit1", rec[42], 1'b1);
        chk("stop2_bit2", rec[46], 1'b1);

        // Fill with transmission held: 8 accepted, 9th dropped; then drain back-to-back.
        par_en   = 1'b0;
        stop2    = 1'b0;
        prescale = 6'd2;
        tx_en    = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_data  = DW'($urandom);
            wr_valid = 1'b1;
            cycle();
        end
        wr_valid = 1'b0;
        chk("full_count", fifo_count, 8);
        chk("full_wr_ready", wr_ready, 1'b0);
        cycle();
        tx_en  = 1'b1;
        n_busy = 0;
        drain(500);
        chk("b2b_busy_cycles", n_busy, 160);
        chk("b2b_final_count", fifo_count, 0);

        // prescale=0 behaves as one cycle per bit.
        prescale = 6'd0;
        run_frame(DW'($urandom), 15);
        chk("p0_frame_cycles", n_busy, 10);

        // Prescale change mid-frame only affects the following frame.
        prescale = 6'd4;
        n_busy   = 0;
        wr_valid = 1'b1;
        wr_data  = DW'($urandom);
        cycle();
        wr_data  = DW'($urandom);
        cycle();
        wr_valid = 1'b0;
        repeat (10) cycle();
        prescale = 6'd8;
        drain(500);
        chk("presc_change_cycles", n_busy, 120);

        // Simultaneous push and pop with three words queued.
        prescale = 6'd1;
        tx_en    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_data  = DW'($urandom);
            wr_valid = 1'b1;
            cycle();
        end
        tx_en   = 1'b1;
        wr_data = DW'($urandom);
        cycle();
        wr_valid = 1'b0;
        chk("push_pop_count", fifo_count, 3);
        drain(500);

        // Reset while idle.
        do_reset("idle_rst");
        cycle();

        // Randomized traffic with one reset in the middle of a frame.
        did_rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (!did_rst && i > 1500 && line_q.size() > 2) begin
                do_reset("frame_rst");
                did_rst = 1'b1;
            end
            tx_en    = ($urandom_range(0, 7) != 0);
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_data  = DW'($urandom);
            par_en   = $urandom_range(0, 1) != 0;
            par_typ  = $urandom_range(0, 1) != 0;
            stop2    = $urandom_range(0, 1) != 0;
            prescale = PRW'($urandom_range(0, 3));
            cycle();
        end
        chk("frame_rst_seen", did_rst, 1'b1);
        wr_valid = 1'b0;
        tx_en    = 1'b1;
        drain(2000);
        chk("end_count", fifo_count, 0);
        chk("end_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
